// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
//   Parametrised synchronous FIFO for one transaction-layer virtual channel.
//   Owns its read/write pointers and occupancy count, exposes full/empty and
//   programmable almost-full/almost-empty flags, and has a registered read
//   port with a one-cycle valid strobe.
//
//   Optional feature macro: FIFO_ERR_EN
//     defined   -> sticky overflow/underflow error flags are implemented
//     undefined -> err_overflow / err_underflow are tied to 0
//
// Ports
//   clk           : single clock, all state updates on the rising edge
//   reset         : asynchronous, active-high; clears pointers, count,
//                   read port and error flags (storage is not cleared)
//   wr_en/data_in : write request and write data
//   rd_en         : read request
//   thr_af        : almost-full threshold  (almost_full  = count >= thr_af)
//   thr_ae        : almost-empty threshold (almost_empty = count <= thr_ae)
//   data_out      : registered read data, holds value between reads
//   valid_out     : data_out was updated by the last edge
//   full/empty    : count == DEPTH / count == 0
//   count         : occupancy 0..DEPTH
//   err_overflow  : sticky write-while-full (no simultaneous read)
//   err_underflow : sticky read-while-empty
// ---------------------------------------------------------------------------
module fifo_param #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   thr_af,
    input  logic [ADDR_W:0]   thr_ae,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;

    logic rd_acc;
    logic wr_acc;

    // Flags are purely combinational from the registered count, so threshold
    // changes are visible in the same cycle.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= thr_af);
    assign almost_empty = (count_q <= thr_ae);
    assign count        = count_q;
    assign data_out     = data_out_q;
    assign valid_out    = valid_q;

    always_comb begin
        // A read is only taken when there is data; no write-to-read bypass
        // on an empty FIFO. A read on a full FIFO frees a slot for a write.
        rd_acc = rd_en && !empty;
        wr_acc = wr_en && (!full || rd_acc);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = mem_q[rd_ptr_q];
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    // Storage has no reset: reads are gated by empty, so stale entries are
    // never presented on data_out.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    always_comb begin
        // Overflow only when the write is actually dropped (a concurrent
        // accepted read makes room, so that case is not an error).
        err_ovf_d = err_ovf_q | (wr_en & full & ~rd_acc);
        err_udf_d = err_udf_q | (rd_en & empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [9:0] data_in;
    logic       rd_en;
    logic [3:0] thr_af;
    logic [3:0] thr_ae;
    logic [9:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       err_overflow;
    logic       err_underflow;

    int passed = 0;
    int total  = 0;

    // Reference model: a plain queue of words plus the read-port registers.
    logic [9:0] q[$];
    logic [9:0] m_data;
    logic       m_valid;
    logic       m_eo;
    logic       m_eu;

    always #5 clk = ~clk;

    fifo_param #(.DATA_W(10), .ADDR_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .thr_af       (thr_af),
        .thr_ae       (thr_ae),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},     32'(count),        32'(n));
        chk({tag, ".full"},      32'(full),         32'(n == 8));
        chk({tag, ".empty"},     32'(empty),        32'(n == 0));
        chk({tag, ".afull"},     32'(almost_full),  32'(n >= int'(thr_af)));
        chk({tag, ".aempty"},    32'(almost_empty), 32'(n <= int'(thr_ae)));
        chk({tag, ".valid"},     32'(valid_out),    32'(m_valid));
        chk({tag, ".data"},      32'(data_out),     32'(m_data));
        chk({tag, ".err_ovf"},   32'(err_overflow), 32'(m_eo));
        chk({tag, ".err_udf"},   32'(err_underflow),32'(m_eu));
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_eo    = 1'b0;
        m_eu    = 1'b0;
    endtask

    // One clock cycle: drive, let the edge happen, advance the model, check.
    task automatic step(input string tag, input logic w, input logic [9:0] d, input logic r);
        int  n;
        bit  racc;
        bit  wacc;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        n    = q.size();
        racc = r && (n > 0);
        wacc = w && ((n < 8) || racc);
`ifdef FIFO_ERR_EN
        if (w && n == 8 && !racc) m_eo = 1'b1;
        if (r && n == 0)          m_eu = 1'b1;
`endif
        if (racc) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wacc) q.push_back(d);
        #1;
        $display("%s: wr=%0b din=%03h rd=%0b -> count=%0d dout=%03h valid=%0b full=%0b empty=%0b af=%0b ae=%0b eo=%0b eu=%0b",
                 tag, w, d, r, count, data_out, valid_out, full, empty,
                 almost_full, almost_empty, err_overflow, err_underflow);
        check_all(tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        $display("%s: async reset asserted", tag);
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        thr_af  = 4'd6;
        thr_ae  = 4'd2;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill with 0x001..0x008; almost_full rises on the 6th write.
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 10'(i), 1'b0);
        chk("fill.full_at_8", 32'(full), 32'd1);

        // Back-to-back drain, one word per cycle.
        for (int i = 1; i <= 8; i++) begin
            step("drain", 1'b0, '0, 1'b1);
            chk("drain.word", 32'(data_out), 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // Full with simultaneous read+write across the pointer wrap.
        for (int i = 0; i < 8; i++) step("refill", 1'b1, 10'(16 + i), 1'b0);
        for (int i = 0; i < 4; i++) step("rdwr", 1'b1, 10'(32 + i), 1'b1);

        // Dropped write on a full FIFO.
        step("ovf", 1'b1, 10'h3FF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("drain2", 1'b0, '0, 1'b1);
            chk("drain2.no3ff", 32'(data_out == 10'h3FF), 32'd0);
        end

        // Empty with read+write: write taken, read rejected.
        step("udf", 1'b1, 10'h155, 1'b1);
        chk("udf.count1", 32'(count), 32'd1);
        step("udf_rd", 1'b0, '0, 1'b1);
        chk("udf.readback", 32'(data_out), 32'h155);

        // Async reset mid-stream with five words held and a read in flight.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 10'(64 + i), 1'b0);
        step("pre_rst_rd", 1'b0, '0, 1'b1);
        async_reset("mid_rst");
        step("post_rst", 1'b0, '0, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1);

        // Threshold corner cases.
        thr_af = 4'd0;
        thr_ae = 4'd8;
        step("thr_corner", 1'b1, 10'h0AA, 1'b0);
        thr_ae = 4'd15;
        step("thr_corner2", 1'b0, '0, 1'b0);

        // Randomized traffic with occasional threshold changes and resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) thr_af = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) thr_ae = 4'($urandom_range(0, 15));
            if (i == 150) async_reset("rand_rst");
            step("rand", 1'($urandom_range(0, 99) < 55), 10'($urandom),
                 1'($urandom_range(0, 99) < 45));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
